// File: rtl/arm_regs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arm_regs_pkg : modes, physical register indices, CPSR fields, FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package arm_regs_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'h10,
    MODE_IRQ = 5'h12,
    MODE_SVC = 5'h13,
    MODE_ABT = 5'h17,
    MODE_UND = 5'h1B,
    MODE_SYS = 5'h1F
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_LINK = 2'd2
  } exc_state_t;

  localparam int unsigned NUM_GPR  = 24;
  localparam int unsigned NUM_SPSR = 4;

  // Physical word map: 0-15 user bank, 16-23 banked r13/r14, 24 CPSR, 25-28 SPSRs
  localparam logic [4:0] P_R13_USR  = 5'd13;
  localparam logic [4:0] P_R14_USR  = 5'd14;
  localparam logic [4:0] P_R13_SVC  = 5'd16;
  localparam logic [4:0] P_R14_SVC  = 5'd17;
  localparam logic [4:0] P_R13_ABT  = 5'd18;
  localparam logic [4:0] P_R14_ABT  = 5'd19;
  localparam logic [4:0] P_R13_IRQ  = 5'd20;
  localparam logic [4:0] P_R14_IRQ  = 5'd21;
  localparam logic [4:0] P_R13_UND  = 5'd22;
  localparam logic [4:0] P_R14_UND  = 5'd23;
  localparam logic [4:0] P_CPSR     = 5'd24;
  localparam logic [4:0] P_SPSR_SVC = 5'd25;
  localparam logic [4:0] P_SPSR_ABT = 5'd26;
  localparam logic [4:0] P_SPSR_IRQ = 5'd27;
  localparam logic [4:0] P_SPSR_UND = 5'd28;

  localparam int unsigned CPSR_MODE_MSB = 4;
  localparam int unsigned CPSR_F_BIT    = 6;
  localparam int unsigned CPSR_I_BIT    = 7;
  localparam logic [7:0]  CPSR_RESET    = 8'hD3;

  function automatic logic [4:0] map_phys(input logic [3:0] idx,
                                          input logic [4:0] mode,
                                          input logic       usr_bank);
    logic [4:0] p;
    logic       is14;
    p    = {1'b0, idx};
    is14 = (idx == 4'd14);
    if (!usr_bank && (idx == 4'd13 || is14)) begin
      case (mode)
        MODE_SVC: p = is14 ? P_R14_SVC : P_R13_SVC;
        MODE_ABT: p = is14 ? P_R14_ABT : P_R13_ABT;
        MODE_IRQ: p = is14 ? P_R14_IRQ : P_R13_IRQ;
        MODE_UND: p = is14 ? P_R14_UND : P_R13_UND;
        default:  p = is14 ? P_R14_USR : P_R13_USR;
      endcase
    end
    return p;
  endfunction

  function automatic logic has_spsr(input logic [4:0] mode);
    return (mode == MODE_SVC) || (mode == MODE_ABT) ||
           (mode == MODE_IRQ) || (mode == MODE_UND);
  endfunction

  function automatic logic [1:0] spsr_slot(input logic [4:0] mode);
    logic [1:0] s;
    case (mode)
      MODE_ABT: s = 2'd1;
      MODE_IRQ: s = 2'd2;
      MODE_UND: s = 2'd3;
      default:  s = 2'd0;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/banked_reg_map.sv
`default_nettype none
// ---------------------------------------------------------------------------
// banked_reg_map : logical index + mode + user-bank override -> physical index
// Rev 1.0
// ---------------------------------------------------------------------------
module banked_reg_map
  import arm_regs_pkg::*;
(
  input  logic [3:0] idx,
  input  logic [4:0] mode,
  input  logic       usr_bank,
  output logic [4:0] phys
);

  assign phys = map_phys(idx, mode, usr_bank);

endmodule
`default_nettype wire

// File: rtl/banked_register_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// banked_register_file : mode-banked ARM register file with exception entry
// FSM and pending-load scoreboard. Optional macro: REGBANK_BYPASS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module banked_register_file
  import arm_regs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*4-1:0]      rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*4-1:0]      wr_idx,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     usr_bank,
  input  logic                     cpsr_wr_en,
  input  logic                     spsr_wr_en,
  input  logic [DATA_W-1:0]        psr_wr_data,
  output logic [DATA_W-1:0]        cpsr,
  output logic [DATA_W-1:0]        spsr,
  input  logic                     exc_req,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_lr,
  output logic                     exc_ack,
  output logic                     exc_err,
  output logic                     stall,
  input  logic                     busy_set,
  input  logic [3:0]               busy_idx,
  output logic [15:0]              busy
);

  logic [DATA_W-1:0]  regs_q [NUM_GPR];
  logic [DATA_W-1:0]  regs_d [NUM_GPR];
  logic [DATA_W-1:0]  spsr_q [NUM_SPSR];
  logic [DATA_W-1:0]  spsr_d [NUM_SPSR];
  logic [DATA_W-1:0]  cpsr_q, cpsr_d;
  logic [NUM_GPR-1:0] busy_q, busy_d;
  exc_state_t         state_q, state_d;
  logic [4:0]         exc_mode_q, exc_mode_d;
  logic [DATA_W-1:0]  exc_lr_q, exc_lr_d;
  logic               exc_err_q, exc_err_d;

  logic [4:0] cur_mode;
  logic [4:0] rd_phys [NUM_RD];
  logic [4:0] wr_phys [NUM_WR];
  logic [4:0] busy_phys;
  logic       idle;

  assign cur_mode = cpsr_q[CPSR_MODE_MSB:0];
  assign idle     = (state_q == ST_IDLE);

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_map
      banked_reg_map u_map (
        .idx     (rd_idx[p*4 +: 4]),
        .mode    (cur_mode),
        .usr_bank(usr_bank),
        .phys    (rd_phys[p])
      );
    end
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_map
      banked_reg_map u_map (
        .idx     (wr_idx[p*4 +: 4]),
        .mode    (cur_mode),
        .usr_bank(usr_bank),
        .phys    (wr_phys[p])
      );
    end
  endgenerate

  banked_reg_map u_busy_map (
    .idx     (busy_idx),
    .mode    (cur_mode),
    .usr_bank(usr_bank),
    .phys    (busy_phys)
  );

  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    spsr_d     = spsr_q;
    cpsr_d     = cpsr_q;
    busy_d     = busy_q;
    exc_mode_d = exc_mode_q;
    exc_lr_d   = exc_lr_q;
    exc_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ascending port order lets the highest-index port win on conflicts
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p]) begin
            regs_d[wr_phys[p]] = wr_data[p*DATA_W +: DATA_W];
            busy_d[wr_phys[p]] = 1'b0;
          end
        end
        if (busy_set) busy_d[busy_phys] = 1'b1;
        if (cpsr_wr_en) cpsr_d = psr_wr_data;
        if (spsr_wr_en && has_spsr(cur_mode)) spsr_d[spsr_slot(cur_mode)] = psr_wr_data;
        if (exc_req) begin
          if (has_spsr(exc_mode)) begin
            exc_mode_d = exc_mode;
            exc_lr_d   = exc_lr;
            state_d    = ST_SAVE;
          end else begin
            exc_err_d = 1'b1;
          end
        end
      end
      ST_SAVE: begin
        spsr_d[spsr_slot(exc_mode_q)]   = cpsr_q;
        cpsr_d[CPSR_MODE_MSB:0]         = exc_mode_q;
        cpsr_d[CPSR_I_BIT]              = 1'b1;
        state_d                         = ST_LINK;
      end
      ST_LINK: begin
        regs_d[map_phys(4'd14, exc_mode_q, 1'b0)] = exc_lr_q;
        state_d                                   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GPR; i++) regs_q[i] <= '0;
      for (int i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
      cpsr_q     <= {{(DATA_W-8){1'b0}}, CPSR_RESET};
      busy_q     <= '0;
      state_q    <= ST_IDLE;
      exc_mode_q <= '0;
      exc_lr_q   <= '0;
      exc_err_q  <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      spsr_q     <= spsr_d;
      cpsr_q     <= cpsr_d;
      busy_q     <= busy_d;
      state_q    <= state_d;
      exc_mode_q <= exc_mode_d;
      exc_lr_q   <= exc_lr_d;
      exc_err_q  <= exc_err_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [DATA_W-1:0] r;
      r = regs_q[rd_phys[p]];
`ifdef REGBANK_BYPASS_EN
      if (idle) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_phys[w] == rd_phys[p])) r = wr_data[w*DATA_W +: DATA_W];
        end
      end
`endif
      rd_data[p*DATA_W +: DATA_W] = r;
    end
  end

`ifdef REGBANK_BYPASS_EN
  assign cpsr = (idle && cpsr_wr_en) ? psr_wr_data : cpsr_q;
`else
  assign cpsr = cpsr_q;
`endif

  assign spsr = has_spsr(cur_mode) ? spsr_q[spsr_slot(cur_mode)] : '0;

  always_comb begin
    busy = '0;
    for (int i = 0; i < 16; i++) busy[i] = busy_q[map_phys(4'(i), cur_mode, 1'b0)];
  end

  assign exc_ack = (state_q == ST_LINK);
  assign exc_err = exc_err_q;
  assign stall   = !idle;

endmodule
`default_nettype wire

// File: tb/tb_banked_register_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_banked_register_file : directed self-checking bench for banked_register_file
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] rd_idx;
  logic [95:0] rd_data;
  logic [1:0]  wr_en;
  logic [7:0]  wr_idx;
  logic [63:0] wr_data;
  logic        usr_bank, cpsr_wr_en, spsr_wr_en;
  logic [31:0] psr_wr_data, cpsr, spsr, exc_lr;
  logic        exc_req, exc_ack, exc_err, stall, busy_set;
  logic [4:0]  exc_mode;
  logic [3:0]  busy_idx;
  logic [15:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banked_register_file #(.DATA_W(32), .NUM_RD(3), .NUM_WR(2)) dut (
    .clk(clk), .reset_n(reset_n), .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .usr_bank(usr_bank),
    .cpsr_wr_en(cpsr_wr_en), .spsr_wr_en(spsr_wr_en), .psr_wr_data(psr_wr_data),
    .cpsr(cpsr), .spsr(spsr), .exc_req(exc_req), .exc_mode(exc_mode),
    .exc_lr(exc_lr), .exc_ack(exc_ack), .exc_err(exc_err), .stall(stall),
    .busy_set(busy_set), .busy_idx(busy_idx), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  task automatic write1(input logic [3:0] idx, input logic [31:0] d);
    wr_en = 2'b01; wr_idx[3:0] = idx; wr_data[31:0] = d;
    tick();
    wr_en = 2'b00;
  endtask

  task automatic msr(input logic [31:0] d);
    cpsr_wr_en = 1'b1; psr_wr_data = d;
    tick();
    cpsr_wr_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rd_idx = '0; wr_en = '0; wr_idx = '0; wr_data = '0;
    usr_bank = 1'b0; cpsr_wr_en = 1'b0; spsr_wr_en = 1'b0; psr_wr_data = '0;
    exc_req = 1'b0; exc_mode = '0; exc_lr = '0; busy_set = 1'b0; busy_idx = '0;
    #12;
    rd_idx[3:0] = 4'd13;
    #1;
    check("rst_r13", rd(0), 32'h0);
    check("rst_cpsr", cpsr, 32'hD3);
    check("rst_busy", {16'h0, busy}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_ack", {31'h0, exc_ack}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Bank isolation between SVC and USR r13
    write1(4'd13, 32'h1111);
    check("svc_r13", rd(0), 32'h1111);
    msr(32'h10);
    check("usr_cpsr", cpsr, 32'h10);
    check("usr_spsr", spsr, 32'h0);
    check("usr_r13_init", rd(0), 32'h0);
    write1(4'd13, 32'h2222);
    check("usr_r13", rd(0), 32'h2222);
    msr(32'hD3);
    check("svc_r13_back", rd(0), 32'h1111);
    usr_bank = 1'b1;
    #1;
    check("usr_bank_r13", rd(0), 32'h2222);
    usr_bank = 1'b0;
    msr(32'h10);

    // Exception entry USR -> IRQ
    exc_req = 1'b1; exc_mode = 5'h12; exc_lr = 32'h80;
    tick();
    check("save_stall", {31'h0, stall}, 32'h1);
    check("save_ack", {31'h0, exc_ack}, 32'h0);
    check("save_cpsr", cpsr, 32'h10);
    tick();
    check("link_stall", {31'h0, stall}, 32'h1);
    check("link_ack", {31'h0, exc_ack}, 32'h1);
    exc_req = 1'b0;
    tick();
    rd_idx[7:4] = 4'd14;
    #1;
    check("idle_stall", {31'h0, stall}, 32'h0);
    check("idle_ack", {31'h0, exc_ack}, 32'h0);
    check("irq_cpsr", cpsr, 32'h92);
    check("irq_spsr", spsr, 32'h10);
    check("irq_r14", rd(1), 32'h80);

    // Two-port write conflict on r3
    rd_idx[7:4] = 4'd3;
    wr_en = 2'b11; wr_idx = {4'd3, 4'd3}; wr_data = {32'hB, 32'hA};
    #1;
`ifdef REGBANK_BYPASS_EN
    check("conflict_same_cycle", rd(1), 32'hB);
`else
    check("conflict_same_cycle", rd(1), 32'h0);
`endif
    tick();
    wr_en = 2'b00;
    #1;
    check("conflict_r3", rd(1), 32'hB);

    // Scoreboard
    busy_set = 1'b1; busy_idx = 4'd5;
    tick();
    busy_set = 1'b0;
    check("busy_set5", {16'h0, busy}, 32'h0020);
    busy_set = 1'b1;
    write1(4'd5, 32'h55);
    busy_set = 1'b0;
    check("busy_set_wins", {16'h0, busy}, 32'h0020);
    write1(4'd5, 32'h56);
    check("busy_cleared", {16'h0, busy}, 32'h0);
    rd_idx[11:8] = 4'd5;
    #1;
    check("r5_value", rd(2), 32'h56);

    // Invalid exception mode
    exc_req = 1'b1; exc_mode = 5'h10; exc_lr = 32'h99;
    tick();
    exc_req = 1'b0;
    check("inv_err", {31'h0, exc_err}, 32'h1);
    check("inv_stall", {31'h0, stall}, 32'h0);
    tick();
    check("inv_err_drop", {31'h0, exc_err}, 32'h0);
    check("inv_cpsr", cpsr, 32'h92);

    // Asynchronous reset while in SAVE
    exc_req = 1'b1; exc_mode = 5'h13; exc_lr = 32'h44;
    tick();
    exc_req = 1'b0;
    check("rsave_stall", {31'h0, stall}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rsave_cpsr", cpsr, 32'hD3);
    check("rsave_stall_clr", {31'h0, stall}, 32'h0);
    check("rsave_ack", {31'h0, exc_ack}, 32'h0);
    tick();
    rd_idx[3:0] = 4'd14;
    #1;
    check("rsave_r14", rd(0), 32'h0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ack", {31'h0, exc_ack}, 32'h0);
    check("post_rst_cpsr", cpsr, 32'hD3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
